// File: rtl/irrigation_matrix_pkg.sv
// Shared status codes and glyph images for the irrigation LED matrix.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package irrigation_matrix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SPRINKLER = 2'd1,
        ST_DRIP      = 2'd2,
        ST_ERROR     = 2'd3
    } status_e;

    localparam int GLYPH_ROWS = 7;
    localparam int GLYPH_COLS = 5;

    // One 7-bit column image per (status, column); bit 0 is the top row.
    // Column 0 of every glyph is the frame marker the controller firmware
    // relies on, so its values must stay fixed.
    localparam logic [GLYPH_ROWS-1:0] GLYPH [0:3][0:GLYPH_COLS-1] = '{
        '{7'h7F, 7'h63, 7'h5D, 7'h63, 7'h7F},   // idle: framed box
        '{7'h01, 7'h15, 7'h2A, 7'h15, 7'h01},   // sprinkler: spray fan
        '{7'h41, 7'h08, 7'h1C, 7'h3E, 7'h41},   // drip: droplet
        '{7'h01, 7'h22, 7'h14, 7'h22, 7'h01}    // error: cross
    };

endpackage

// File: rtl/irrigation_matrix_scanner_if.sv
// Controller-side bundle for the matrix scanner: status strobe in, scan drive out.
// Latency: n/a (wiring only).
// Backpressure: none; status strobes are always accepted.
interface irrigation_matrix_scanner_if #(
    parameter int NUM_COLS = 5,
    parameter int NUM_ROWS = 7
) ();

    logic                enable;
    logic [1:0]          irrigation_status;
    logic                status_valid;
    logic [NUM_COLS-1:0] col_sel;
    logic [NUM_ROWS-1:0] rows;
    logic                frame_start;

    modport master (
        output enable, irrigation_status, status_valid,
        input  col_sel, rows, frame_start
    );

    modport slave (
        input  enable, irrigation_status, status_valid,
        output col_sel, rows, frame_start
    );

endinterface

// File: rtl/irrigation_glyph_rom.sv
// Combinational (status, column) -> row image lookup with row truncation/zero-fill.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module irrigation_glyph_rom
    import irrigation_matrix_pkg::*;
#(
    parameter int NUM_ROWS = 7,
    parameter int COL_W    = 3
) (
    input  status_e             status,
    input  logic [COL_W-1:0]    col_idx,
    output logic [NUM_ROWS-1:0] rows
);

    logic [GLYPH_ROWS-1:0] img;

    // Columns beyond the glyph width read as blank.
    always_comb begin
        img = '0;
        for (int c = 0; c < GLYPH_COLS; c++) begin
            if (int'(col_idx) == c) begin
                img = GLYPH[status][c];
            end
        end
    end

    // Keep the low glyph rows; any rows beyond the glyph height stay dark.
    always_comb begin
        rows = '0;
        for (int r = 0; r < NUM_ROWS && r < GLYPH_ROWS; r++) begin
            rows[r] = img[r];
        end
    end

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Time-multiplexed LED matrix driver: frame-aligned status, column scan, error blink.
// Latency: first column SCAN_DIV edges after enable; then one column per SCAN_DIV cycles.
// Backpressure: none; status strobes always land in the pending register (last wins).
module irrigation_matrix_scanner
    import irrigation_matrix_pkg::*;
#(
    parameter int NUM_COLS     = 5,
    parameter int NUM_ROWS     = 7,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50
) (
    input  logic                         clk,
    input  logic                         reset,
    irrigation_matrix_scanner_if.slave   bus
);

    localparam int COL_W = $clog2(NUM_COLS);
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRE_W-1:0]    prescaler;
    logic [COL_W-1:0]    col_idx;
    status_e             pending;
    status_e             active;
    logic [BLK_W-1:0]    blink_cnt;
    logic                blink_phase;

    status_e             status_in;
    status_e             pending_eff;
    status_e             active_next;
    logic                tick;
    logic                boundary;
    logic [BLK_W-1:0]    blink_cnt_next;
    logic                blink_phase_next;
    logic [NUM_ROWS-1:0] rom_rows;
    logic [NUM_COLS-1:0] col_onehot;
    logic [NUM_COLS-1:0] col_sel_q;
    logic [NUM_ROWS-1:0] rows_q;
    logic                frame_start_q;

    assign status_in   = status_e'(bus.irrigation_status);
    assign tick        = bus.enable && (prescaler == PRE_W'(SCAN_DIV - 1));
    assign boundary    = tick && (col_idx == '0);
    // A strobe coinciding with a boundary bypasses pending so column 0 shows it.
    assign pending_eff = bus.status_valid ? status_in : pending;
    assign active_next = boundary ? pending_eff : active;
    assign col_onehot  = {{(NUM_COLS-1){1'b0}}, 1'b1} << col_idx;

    irrigation_glyph_rom #(
        .NUM_ROWS (NUM_ROWS),
        .COL_W    (COL_W)
    ) u_glyph_rom (
        .status  (active_next),
        .col_idx (col_idx),
        .rows    (rom_rows)
    );

    // Blink bookkeeping advances only at frame boundaries; any boundary that
    // enters or stays out of error restarts the half-period visible.
    always_comb begin
        blink_cnt_next   = blink_cnt;
        blink_phase_next = blink_phase;
        if (boundary) begin
            if (active_next != ST_ERROR || active != ST_ERROR) begin
                blink_cnt_next   = '0;
                blink_phase_next = 1'b1;
            end else if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next   = blink_cnt + 1'b1;
            end
        end
    end

    // Double-buffered status: pending takes every strobe, active moves only at frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= ST_IDLE;
            active  <= ST_IDLE;
        end else begin
            if (bus.status_valid) begin
                pending <= status_in;
            end
            active <= active_next;
        end
    end

    // Scan counters; disabling parks everything at the start of a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler   <= '0;
            col_idx     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!bus.enable) begin
            prescaler   <= '0;
            col_idx     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            prescaler   <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                col_idx <= (col_idx == COL_W'(NUM_COLS - 1)) ? '0 : col_idx + 1'b1;
            end
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
        end
    end

    // Registered pin drive; a blanked blink phase darkens rows but keeps the column scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_sel_q     <= '0;
            rows_q        <= '0;
            frame_start_q <= 1'b0;
        end else if (!bus.enable) begin
            col_sel_q     <= '0;
            rows_q        <= '0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= boundary;
            if (tick) begin
                col_sel_q <= col_onehot;
                rows_q    <= blink_phase_next ? rom_rows : '0;
            end
        end
    end

    assign bus.col_sel     = col_sel_q;
    assign bus.rows        = rows_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_irrigation_matrix_scanner.sv
// Directed plus randomized bench for irrigation_matrix_scanner against a frame-level model.
// Latency: model predicts outputs per clock edge; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_irrigation_matrix_scanner;
    import irrigation_matrix_pkg::*;

    localparam int NC = 5;
    localparam int NR = 7;
    localparam int SD = 4;
    localparam int BF = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    irrigation_matrix_scanner_if #(.NUM_COLS(NC), .NUM_ROWS(NR)) bus ();

    irrigation_matrix_scanner #(
        .NUM_COLS     (NC),
        .NUM_ROWS     (NR),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time since enable, latest strobed status, status shown
    // in the current frame, and number of frame starts since error was entered.
    int           m_t;
    int           m_err_idx;
    logic [1:0]   m_pending;
    logic [1:0]   m_shown;
    logic [NC-1:0] e_col;
    logic [NR-1:0] e_rows;
    logic          e_fs;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t       = 0;
        m_err_idx = 0;
        m_pending = 2'd0;
        m_shown   = 2'd0;
        e_col     = '0;
        e_rows    = '0;
        e_fs      = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit sv, input logic [1:0] st);
        int         k;
        int         col;
        logic [1:0] nxt;
        logic [6:0] img;
        bit         vis;
        if (!en) begin
            m_t       = 0;
            m_err_idx = 0;
            e_col     = '0;
            e_rows    = '0;
            e_fs      = 1'b0;
            if (sv) m_pending = st;
            return;
        end
        m_t++;
        e_fs = 1'b0;
        if (m_t % SD == 0) begin
            k   = m_t / SD - 1;
            col = k % NC;
            if (col == 0) begin
                nxt = sv ? st : m_pending;
                if (nxt == 2'd3 && m_shown == 2'd3) m_err_idx++;
                else m_err_idx = 0;
                m_shown = nxt;
                e_fs    = 1'b1;
            end
            img = (col < GLYPH_COLS) ? GLYPH[m_shown][col] : 7'h00;
            vis = (m_shown != 2'd3) || (((m_err_idx / BF) % 2) == 0);
            e_col      = '0;
            e_col[col] = 1'b1;
            e_rows     = vis ? img : 7'h00;
        end
        if (sv) m_pending = st;
    endtask

    task automatic cyc(input bit en, input bit sv, input logic [1:0] st);
        bus.enable            = en;
        bus.status_valid      = sv;
        bus.irrigation_status = st;
        @(posedge clk);
        model_edge(en, sv, st);
        @(negedge clk);
        check("col_sel",     16'(bus.col_sel),     16'(e_col));
        check("rows",        16'(bus.rows),        16'(e_rows));
        check("frame_start", 16'(bus.frame_start), 16'(e_fs));
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cyc(en, 1'b0, 2'b00);
    endtask

    initial begin
        reset                 = 1'b1;
        bus.enable            = 1'b0;
        bus.status_valid      = 1'b0;
        bus.irrigation_status = 2'b00;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_col_sel", 16'(bus.col_sel),     16'h0000);
        check("reset_rows",    16'(bus.rows),        16'h0000);
        check("reset_fs",      16'(bus.frame_start), 16'h0000);
        reset = 1'b0;

        // First column four edges after enable, then one column every four cycles.
        run(4, 1'b1);
        check("first_col",  16'(bus.col_sel),     16'h0001);
        check("first_rows", 16'(bus.rows),        16'h007F);
        check("first_fs",   16'(bus.frame_start), 16'h0001);
        run(1, 1'b1);
        check("fs_single_cycle", 16'(bus.frame_start), 16'h0000);
        run(19, 1'b1);
        check("wrap_col", 16'(bus.col_sel),     16'h0001);
        check("wrap_fs",  16'(bus.frame_start), 16'h0001);

        // Strobe drip during column 2: rest of frame stays idle.
        run(8, 1'b1);
        check("col2", 16'(bus.col_sel), 16'h0004);
        cyc(1'b1, 1'b1, 2'b10);
        run(3, 1'b1);
        check("col3_still_idle", 16'(bus.rows), 16'h0063);
        run(8, 1'b1);
        check("drip_col0", 16'(bus.rows), 16'h0041);

        // Strobe on the exact boundary tick goes straight to column 0.
        run(19, 1'b1);
        cyc(1'b1, 1'b1, 2'b01);
        check("bypass_rows", 16'(bus.rows),        16'h0001);
        check("bypass_fs",   16'(bus.frame_start), 16'h0001);

        // Error blink with two frames per half-period.
        cyc(1'b1, 1'b1, 2'b11);
        run(19, 1'b1);
        check("err_f0_rows", 16'(bus.rows), 16'h0001);
        run(20, 1'b1);
        check("err_f1_rows", 16'(bus.rows), 16'h0001);
        run(20, 1'b1);
        check("err_f2_rows", 16'(bus.rows),    16'h0000);
        check("err_f2_col",  16'(bus.col_sel), 16'h0001);
        run(4, 1'b1);
        check("err_f2_scan", 16'(bus.col_sel), 16'h0002);
        run(16, 1'b1);
        check("err_f3_rows", 16'(bus.rows), 16'h0000);
        run(20, 1'b1);
        check("err_f4_rows", 16'(bus.rows), 16'h0001);
        cyc(1'b1, 1'b1, 2'b00);
        run(19, 1'b1);
        check("leave_err_rows", 16'(bus.rows), 16'h007F);

        // Drop enable at column 3, then re-enable.
        run(12, 1'b1);
        check("col3_before_drop", 16'(bus.col_sel), 16'h0008);
        cyc(1'b0, 1'b0, 2'b00);
        check("drop_col_sel", 16'(bus.col_sel), 16'h0000);
        check("drop_rows",    16'(bus.rows),    16'h0000);
        run(2, 1'b0);
        run(3, 1'b1);
        check("reen_blank", 16'(bus.col_sel), 16'h0000);
        run(1, 1'b1);
        check("reen_col0", 16'(bus.col_sel),     16'h0001);
        check("reen_fs",   16'(bus.frame_start), 16'h0001);

        // Random strobes checked against the model every cycle.
        for (int i = 0; i < 800; i++) begin
            cyc(1'b1, ($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)));
        end

        // Asynchronous reset between edges, with a drip strobe pending.
        cyc(1'b1, 1'b1, 2'b10);
        bus.status_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_col_sel", 16'(bus.col_sel),     16'h0000);
        check("async_rows",    16'(bus.rows),        16'h0000);
        check("async_fs",      16'(bus.frame_start), 16'h0000);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(4, 1'b1);
        check("post_reset_idle_rows", 16'(bus.rows),    16'h007F);
        check("post_reset_col",       16'(bus.col_sel), 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
